// File: rtl/sio_niu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sio_niu_pkg
//  Description : Shared transmit-FSM state encoding, completion command codes
//                and header bit positions for the SIO-to-NIU transmit path.
//  Revision    : 1.0 - initial release
// ============================================================================
package sio_niu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_D0   = 3'd2,
        ST_D1   = 3'd3,
        ST_D2   = 3'd4,
        ST_D3   = 3'd5
    } state_t;

    localparam logic [2:0] c_cmd_rd_ret = 3'b001;
    localparam logic [2:0] c_cmd_wr_ack = 3'b010;

    localparam int c_hdr_tag_lsb = 64;
    localparam int c_hdr_cmd_lsb = 80;
    localparam int c_hdr_err_bit = 83;

    localparam int c_beat_w  = 128;
    localparam int c_line_w  = 512;
    localparam int c_lane_w  = 16;
    localparam int c_num_lanes = c_beat_w / c_lane_w;

endpackage : sio_niu_pkg
`default_nettype wire

// File: rtl/sio_niu_credit_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : sio_niu_credit_ctr
//  Description : NIU inbound-queue credit counter; saturates at CREDITS and
//                latches a sticky error on a return that would overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module sio_niu_credit_ctr #(
    parameter int CREDITS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_dec,
    input  logic       i_inc,
    output logic [3:0] o_cnt,
    output logic       o_err
);

    localparam logic [3:0] c_max = CREDITS[3:0];

    logic [3:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    // A simultaneous consume and return cancel, even when the count is full.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (i_inc && !i_dec) begin
            if (cnt_q == c_max) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end else if (i_dec && !i_inc) begin
            if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= c_max;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign o_cnt = cnt_q;
    assign o_err = err_q;

endmodule : sio_niu_credit_ctr
`default_nettype wire

// File: rtl/sio_to_niu_xmt.sv
`default_nettype none
// ============================================================================
//  Module      : sio_to_niu_xmt
//  Description : Formats DMA completions (read return / write ack) into a
//                header + payload beat stream toward the NIU, credit-gated.
//                Lane parity is generated when SIO_TO_NIU_PARITY_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module sio_to_niu_xmt
    import sio_niu_pkg::*;
#(
    parameter int CREDITS = 4,
    parameter int TAG_W   = 16
) (
    input  logic             iol2clk,
    input  logic             rst,
    input  logic             req_vld,
    output logic             req_rdy,
    input  logic             req_cmd,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             req_err,
    input  logic [511:0]     req_data,
    output logic             sio_niu_hdr_vld,
    output logic             sio_niu_datareq,
    output logic [127:0]     sio_niu_data,
    output logic [7:0]       sio_niu_parity,
    input  logic             niu_sio_dq,
    output logic [3:0]       credit_cnt,
    output logic             credit_err
);

    state_t                state_q, state_d;
    logic                  cmd_q, cmd_d;
    logic [c_line_w-1:0]   line_q, line_d;
    logic                  hdr_vld_q, hdr_vld_d;
    logic                  datareq_q, datareq_d;
    logic [c_beat_w-1:0]   data_q, data_d;
    logic [7:0]            parity_q, parity_d;

    logic                  w_final;
    logic                  w_accept;
    logic [c_beat_w-1:0]   w_hdr;

    // The credit is consumed on the edge that launches the header, so
    // credit_cnt already reflects it while the header is on the bus and
    // a zero count blocks any further accept.
    assign w_final  = ((state_q == ST_HDR) && !cmd_q) || (state_q == ST_D3);
    assign req_rdy  = !rst && (credit_cnt != 4'd0) &&
                      ((state_q == ST_IDLE) || w_final);
    assign w_accept = req_vld && req_rdy;

    always_comb begin
        w_hdr = '0;
        w_hdr[c_hdr_tag_lsb +: TAG_W] = req_tag;
        w_hdr[c_hdr_cmd_lsb +: 3]     = req_cmd ? c_cmd_rd_ret : c_cmd_wr_ack;
        w_hdr[c_hdr_err_bit]          = req_err;
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        line_d    = line_q;
        hdr_vld_d = 1'b0;
        datareq_d = 1'b0;
        data_d    = '0;

        case (state_q)
            ST_HDR:  state_d = cmd_q ? ST_D0 : ST_IDLE;
            ST_D0:   state_d = ST_D1;
            ST_D1:   state_d = ST_D2;
            ST_D2:   state_d = ST_D3;
            ST_D3:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (w_accept) begin
            state_d = ST_HDR;
            cmd_d   = req_cmd;
            if (req_cmd) begin
                line_d = req_data;
            end
        end

        case (state_d)
            ST_HDR: begin
                hdr_vld_d = 1'b1;
                datareq_d = cmd_d;
                data_d    = w_hdr;
            end
            ST_D0:   data_d = line_q[0*c_beat_w +: c_beat_w];
            ST_D1:   data_d = line_q[1*c_beat_w +: c_beat_w];
            ST_D2:   data_d = line_q[2*c_beat_w +: c_beat_w];
            ST_D3:   data_d = line_q[3*c_beat_w +: c_beat_w];
            default: data_d = '0;
        endcase
    end

`ifdef SIO_TO_NIU_PARITY_EN
    logic [c_num_lanes-1:0] w_par;

    for (genvar i = 0; i < c_num_lanes; i++) begin : g_lane_par
        assign w_par[i] = ~(^data_d[i*c_lane_w +: c_lane_w]);
    end

    // Idle bus carries all-zero data, which would otherwise show odd parity 1s.
    assign parity_d = (state_d == ST_IDLE) ? 8'h00 : w_par;
`else
    assign parity_d = 8'h00;
`endif

    always_ff @(posedge iol2clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cmd_q     <= 1'b0;
            hdr_vld_q <= 1'b0;
            datareq_q <= 1'b0;
            data_q    <= '0;
            parity_q  <= 8'h00;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            hdr_vld_q <= hdr_vld_d;
            datareq_q <= datareq_d;
            data_q    <= data_d;
            parity_q  <= parity_d;
        end
    end

    // Line buffer is pure datapath; its content is only observed after a capture.
    always_ff @(posedge iol2clk) begin
        line_q <= line_d;
    end

    sio_niu_credit_ctr #(
        .CREDITS (CREDITS)
    ) u_credit_ctr (
        .clk   (iol2clk),
        .rst   (rst),
        .i_dec (w_accept),
        .i_inc (niu_sio_dq),
        .o_cnt (credit_cnt),
        .o_err (credit_err)
    );

    assign sio_niu_hdr_vld = hdr_vld_q;
    assign sio_niu_datareq = datareq_q;
    assign sio_niu_data    = data_q;
    assign sio_niu_parity  = parity_q;

endmodule : sio_to_niu_xmt
`default_nettype wire

// File: tb/tb_sio_to_niu_xmt.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sio_to_niu_xmt
//  Description : Self-checking bench for sio_to_niu_xmt against a queue-based
//                model of the completion stream and credit rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sio_to_niu_xmt;

    localparam int CREDITS = 4;
    localparam int TAG_W   = 16;

    logic             iol2clk = 1'b0;
    logic             rst;
    logic             req_vld;
    logic             req_rdy;
    logic             req_cmd;
    logic [TAG_W-1:0] req_tag;
    logic             req_err;
    logic [511:0]     req_data;
    logic             sio_niu_hdr_vld;
    logic             sio_niu_datareq;
    logic [127:0]     sio_niu_data;
    logic [7:0]       sio_niu_parity;
    logic             niu_sio_dq;
    logic [3:0]       credit_cnt;
    logic             credit_err;

    always #5 iol2clk = ~iol2clk;

    sio_to_niu_xmt #(
        .CREDITS (CREDITS),
        .TAG_W   (TAG_W)
    ) dut (
        .iol2clk         (iol2clk),
        .rst             (rst),
        .req_vld         (req_vld),
        .req_rdy         (req_rdy),
        .req_cmd         (req_cmd),
        .req_tag         (req_tag),
        .req_err         (req_err),
        .req_data        (req_data),
        .sio_niu_hdr_vld (sio_niu_hdr_vld),
        .sio_niu_datareq (sio_niu_datareq),
        .sio_niu_data    (sio_niu_data),
        .sio_niu_parity  (sio_niu_parity),
        .niu_sio_dq      (niu_sio_dq),
        .credit_cnt      (credit_cnt),
        .credit_err      (credit_err)
    );

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic         v;
        logic         hv;
        logic         dr;
        logic [127:0] d;
    } word_t;

    // Model: queue of bus words still to appear, the word on the bus now,
    // and the credit pool.
    word_t m_q[$];
    word_t m_cur;
    int    m_credit;
    logic  m_err;
    logic  m_rdy   = 1'b0;
    logic  m_valid = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic  acc;
        word_t w;
        if (rst) begin
            m_q.delete();
            m_cur    = '0;
            m_credit = CREDITS;
            m_err    = 1'b0;
            m_valid  = 1'b1;
            return;
        end
        if (!m_valid) return;
        acc = req_vld && m_rdy;
        if (niu_sio_dq && !acc) begin
            if (m_credit == CREDITS) m_err = 1'b1;
            else m_credit = m_credit + 1;
        end else if (acc && !niu_sio_dq) begin
            m_credit = m_credit - 1;
        end
        if (acc) begin
            w.v  = 1'b1;
            w.hv = 1'b1;
            w.dr = req_cmd;
            w.d  = (128'(req_tag) << 64) | (128'(req_cmd ? 1 : 2) << 80) | (128'(req_err) << 83);
            m_q.push_back(w);
            if (req_cmd) begin
                for (int k = 0; k < 4; k++) begin
                    w.v  = 1'b1;
                    w.hv = 1'b0;
                    w.dr = 1'b0;
                    w.d  = req_data[128*k +: 128];
                    m_q.push_back(w);
                end
            end
        end
        if (m_q.size() > 0) m_cur = m_q.pop_front();
        else m_cur = '0;
    endtask

    task automatic compare();
        logic [7:0] ep;
        ep = 8'h00;
        m_rdy = m_valid && !rst && (m_credit > 0) && (m_q.size() == 0);
        if (!m_valid) return;
`ifdef SIO_TO_NIU_PARITY_EN
        if (m_cur.v) begin
            for (int i = 0; i < 8; i++) ep[i] = ~(^m_cur.d[16*i +: 16]);
        end
`endif
        chk("req_rdy",    req_rdy,         m_rdy);
        chk("hdr_vld",    sio_niu_hdr_vld, m_cur.hv);
        chk("datareq",    sio_niu_datareq, m_cur.dr);
        chk("data",       sio_niu_data,    m_cur.d);
        chk("parity",     sio_niu_parity,  ep);
        chk("credit_cnt", credit_cnt,      128'(m_credit));
        chk("credit_err", credit_err,      m_err);
    endtask

    task automatic cyc(input logic vld, input logic cmd, input logic [15:0] tag,
                       input logic err, input logic [511:0] data,
                       input logic dq, input logic r);
        @(posedge iol2clk);
        model_edge();
        @(negedge iol2clk);
        req_vld    = vld;
        req_cmd    = cmd;
        req_tag    = tag;
        req_err    = err;
        req_data   = data;
        niu_sio_dq = dq;
        rst        = r;
        #1;
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 16'h0, 1'b0, '0, 1'b0, 1'b1);
    endtask

    logic [511:0] pat;
    logic [511:0] rnd;
    logic [7:0]   par_exp;

    initial begin
        rst = 1'b1; req_vld = 1'b0; req_cmd = 1'b0; req_tag = '0;
        req_err = 1'b0; req_data = '0; niu_sio_dq = 1'b0;

        // Reset state
        do_reset();
        chk("rst_rdy", req_rdy, 1'b0);
        idle(1);
        chk("rst_credit", credit_cnt, 4'd4);
        chk("rst_data", sio_niu_data, 128'h0);

        // Read return, tag 00A5
        pat = 512'h03020100;
        cyc(1'b1, 1'b1, 16'h00A5, 1'b0, pat, 1'b0, 1'b0);
        chk("rd_rdy", req_rdy, 1'b1);
        idle(1);
        chk("rd_hdr", sio_niu_data, 128'h0000_0000_0001_00A5_0000_0000_0000_0000);
        chk("rd_hdr_vld", sio_niu_hdr_vld, 1'b1);
        chk("rd_datareq", sio_niu_datareq, 1'b1);
        idle(1);
        chk("rd_beat0", sio_niu_data, 128'h03020100);
        idle(3);
        idle(1);
        chk("rd_idle_after", sio_niu_data, 128'h0);

        // Five back-to-back write acks with no credit return
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 16'h0005, 1'b0, '0, 1'b0, 1'b0);
        chk("wr_credit0", credit_cnt, 4'd0);
        chk("wr_rdy_low", req_rdy, 1'b0);
        cyc(1'b1, 1'b0, 16'h0005, 1'b0, '0, 1'b1, 1'b0);
        chk("wr_dq_not_counted", req_rdy, 1'b0);
        cyc(1'b1, 1'b0, 16'h0005, 1'b0, '0, 1'b0, 1'b0);
        chk("wr_credit1", credit_cnt, 4'd1);
        idle(1);
        chk("wr_hdr5", sio_niu_data, 128'h0000_0000_0002_0005_0000_0000_0000_0000);
        chk("wr_hdr5_vld", sio_niu_hdr_vld, 1'b1);

        // Credit return coincident with header launch at credit 2
        do_reset();
        cyc(1'b1, 1'b0, 16'h0011, 1'b0, '0, 1'b0, 1'b0);
        idle(1);
        cyc(1'b1, 1'b0, 16'h0012, 1'b0, '0, 1'b0, 1'b0);
        idle(1);
        chk("coinc_pre", credit_cnt, 4'd2);
        cyc(1'b1, 1'b0, 16'h0013, 1'b1, '0, 1'b1, 1'b0);
        idle(1);
        chk("coinc_credit", credit_cnt, 4'd2);

        // Overflow return at full credit
        do_reset();
        cyc(1'b0, 1'b0, 16'h0, 1'b0, '0, 1'b1, 1'b0);
        idle(1);
        chk("ovf_credit", credit_cnt, 4'd4);
        chk("ovf_err", credit_err, 1'b1);
        idle(3);
        chk("ovf_sticky", credit_err, 1'b1);
        do_reset();
        idle(1);
        chk("ovf_cleared", credit_err, 1'b0);

        // Reset during D1
        for (int k = 0; k < 16; k++) rnd[32*k +: 32] = $urandom;
        cyc(1'b1, 1'b1, 16'h0BEE, 1'b0, rnd, 1'b0, 1'b0);
        idle(2);
        do_reset();
        chk("mid_rst_rdy", req_rdy, 1'b0);
        idle(1);
        chk("mid_rst_data", sio_niu_data, 128'h0);
        chk("mid_rst_vld", sio_niu_hdr_vld, 1'b0);
        chk("mid_rst_credit", credit_cnt, 4'd4);
        idle(1);
        chk("mid_rst_no_d2", sio_niu_data, 128'h0);

        // Lane-0 all-ones beat parity
        pat = 512'hFFFF;
`ifdef SIO_TO_NIU_PARITY_EN
        par_exp = 8'hFF;
`else
        par_exp = 8'h00;
`endif
        cyc(1'b1, 1'b1, 16'h0001, 1'b0, pat, 1'b0, 1'b0);
        idle(2);
        chk("par_beat0_data", sio_niu_data, 128'hFFFF);
        chk("par_beat0", sio_niu_parity, par_exp);

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 16; k++) rnd[32*k +: 32] = $urandom;
            cyc(($urandom % 10) < 6, 1'($urandom), 16'($urandom), 1'($urandom), rnd,
                ($urandom % 4) == 0, ($urandom % 200) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sio_to_niu_xmt
`default_nettype wire

// File: doc/sio_to_niu_xmt.md
SIO_TO_NIU_XMT -- requirements
Module: sio_to_niu_xmt

Interface
REQ-001 SHALL have parameter CREDITS, default 4, NIU inbound-queue credits granted at reset (1..15).
REQ-002 SHALL have parameter TAG_W, default 16, DMA tag width.
REQ-003 SHALL have port iol2clk  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port req_vld  in  1  completion request valid.
REQ-006 SHALL have port req_rdy  out  1  request accepted when req_vld && req_rdy.
REQ-007 SHALL have port req_cmd  in  1  1 = DMA read return (header + 4 beats); 0 = DMA write ack (header only).
REQ-008 SHALL have port req_tag  in  TAG_W  NIU tag echoed in header.
REQ-009 SHALL have port req_err  in  1  uncorrectable-error flag for header.
REQ-010 SHALL have port req_data  in  512  64-byte read-return line; ignored for write ack.
REQ-011 SHALL have port sio_niu_hdr_vld  out  1  header cycle strobe.
REQ-012 SHALL have port sio_niu_datareq  out  1  high on header cycle of a read return only.
REQ-013 SHALL have port sio_niu_data  out  128  header or payload beat.
REQ-014 SHALL have port sio_niu_parity  out  8  per-16-bit-lane parity of sio_niu_data.
REQ-015 SHALL have port niu_sio_dq  in  1  one-cycle pulse returning one credit.
REQ-016 SHALL have port credit_cnt  out  4  current credits available.
REQ-017 SHALL have port credit_err  out  1  sticky credit-overflow flag.

Function
REQ-018 SHALL implement FSM IDLE, HDR, D0, D1, D2, D3; D0..D3 entered only for read return.
REQ-019 SHALL assert req_rdy iff credit_cnt > 0 and FSM is IDLE or in the final cycle of a packet (HDR for write ack, D3 for read return); credit returned in the same cycle not counted.
REQ-020 SHALL register the request on accept at cycle T and drive the header at T+1, beats at T+2..T+5.
REQ-021 SHALL format header: data[TAG_W+63:64] = tag, [82:80] = 001 read return / 010 write ack, [83] = err, all other bits 0.
REQ-022 SHALL drive beat k (k = 0..3) = req_data[128k+127:128k].
REQ-023 SHALL permit back-to-back packets with zero idle cycles between a final cycle and the next header.
REQ-024 SHALL drive sio_niu_data and sio_niu_parity to 0 in IDLE and hold no stale data.
REQ-025 SHALL decrement credit_cnt on each header cycle and increment it on each niu_sio_dq; simultaneous events leave it unchanged.
REQ-026 SHALL saturate credit_cnt at CREDITS and set credit_err on a dq that would exceed CREDITS; credit_err clears only on rst.
REQ-027 SHALL never issue a header with credit_cnt = 0 (underflow impossible by construction).

Reset
REQ-028 SHALL on rst: FSM to IDLE, credit_cnt = CREDITS, credit_err = 0, req_rdy = 0 that cycle, all sio_niu_* outputs = 0.
REQ-029 SHALL drop an in-flight packet on rst mid-packet; no further beats of it are driven.

Configuration
REQ-030 SHALL compute sio_niu_parity[i] = odd parity of sio_niu_data[16i+15:16i] (XOR of lane bits inverted) when SIO_TO_NIU_PARITY_EN is defined.
REQ-031 SHALL drive sio_niu_parity = 8'h00 constantly when SIO_TO_NIU_PARITY_EN is undefined.

Structure
REQ-032 SHALL place FSM state enum, command codes (001/010), and header bit positions in shared package sio_niu_pkg.
REQ-033 SHALL implement credit counting in sub-module sio_niu_credit_ctr (count, saturate, sticky error).

Verification
REQ-034 SHALL cover: read return tag 16'h00A5, data = 512'h0..0_03_02_01_00 pattern -> hdr at T+1 with [82:80]=001, datareq=1, four beats at T+2..T+5, beat0 = low 128 bits.
REQ-035 SHALL cover: 5 write acks with no dq, CREDITS=4 -> 4 headers issued, req_rdy low after 4th, credit_cnt=0; one dq -> 5th header next cycle.
REQ-036 SHALL cover: dq coincident with header at credit_cnt=2 -> credit_cnt stays 2.
REQ-037 SHALL cover: dq at credit_cnt=4 -> credit_cnt stays 4, credit_err=1 until rst.
REQ-038 SHALL cover: rst asserted during D1 -> next cycle all outputs 0, credit_cnt=4, no D2/D3.
REQ-039 SHALL cover: beat 128'hFFFF in lane 0 with macro defined -> parity[0]=1; macro undefined -> parity=8'h00.
